// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register file write port among NREQ writeback units.
// Grants are registered onto we3/wa3/wd3 one cycle later; R15 writes go to the pc_we/pc_wd pulse instead.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              we3,
  output logic [AW-1:0]     wa3,
  output logic [DW-1:0]     wd3,
  output logic              pc_we,
  output logic [DW-1:0]     pc_wd,
  output logic [1:0]        grant_id
);
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("regfile_wb_arbiter: NREQ must be in 2..4");
  end
  logic [1:0] rr_ptr, sel, idx, nxt_ptr;
  logic found, go, to_pc;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  // Walk from the farthest offset back to rr_ptr so the closest valid requester wins.
  always_comb begin
    found = 1'b0;
    sel = rr_ptr;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 2'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    go = found && !reset && !flush;
    sel_addr = req_addr[sel*AW +: AW];
    sel_data = req_data[sel*DW +: DW];
    to_pc = sel_addr == AW'(15);
    nxt_ptr = (int'(sel) == NREQ - 1) ? 2'd0 : sel + 2'd1;
    req_ready = go ? NREQ'(1) << sel : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      pc_we <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      pc_wd <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
    end else begin
      we3 <= go && !to_pc;
      pc_we <= go && to_pc;
      if (go) begin
        rr_ptr <= nxt_ptr;
        grant_id <= sel;
        if (to_pc) pc_wd <= sel_data;
        else begin
          wa3 <= sel_addr;
          wd3 <= sel_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench; each cycle's expected outputs are queued when the grant is driven.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [2:0] req_valid = '0;
  logic [11:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0] req_ready;
  logic we3, pc_we;
  logic [3:0] wa3;
  logic [31:0] wd3, pc_wd;
  logic [1:0] grant_id;
  logic [71:0] sbq[$];
  logic [3:0] m_wa = '0;
  logic [31:0] m_wd = '0, m_pcwd = '0;
  logic [1:0] m_id = '0;
  logic [31:0] rf [16];
  int n_asr = 0, n_fail = 0;
  wire [71:0] obs = {we3, pc_we, wa3, wd3, pc_wd, grant_id};

  regfile_wb_arbiter #(.NREQ(3), .DW(32), .AW(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
    .pc_we(pc_we), .pc_wd(pc_wd), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Reference register file fed by the write port
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 16; i++) rf[i] <= '0;
    else if (we3 === 1'b1) rf[wa3] <= wd3;
  end

  // Queue the outputs expected one cycle after a cycle whose grant is rdy.
  task automatic predict(input logic [2:0] rdy);
    logic [1:0] id;
    logic [3:0] a;
    logic [31:0] d;
    if (reset) begin
      m_wa = '0; m_wd = '0; m_pcwd = '0; m_id = '0;
      sbq.push_back('0);
    end else if (rdy == 3'b000) sbq.push_back({2'b00, m_wa, m_wd, m_pcwd, m_id});
    else begin
      id = rdy[2] ? 2'd2 : rdy[1] ? 2'd1 : 2'd0;
      a = req_addr[id*4 +: 4];
      d = req_data[id*32 +: 32];
      m_id = id;
      if (a == 4'd15) begin
        m_pcwd = d;
        sbq.push_back({2'b01, m_wa, m_wd, m_pcwd, m_id});
      end else begin
        m_wa = a;
        m_wd = d;
        sbq.push_back({2'b10, m_wa, m_wd, m_pcwd, m_id});
      end
    end
  endtask

  task automatic test_reset;
    logic [71:0] e;
    logic [2:0] er;
    req_addr = {4'd5, 4'd4, 4'd3};
    req_data = {32'h5, 32'h4, 32'h3};
    req_valid = 3'b111;
    @(posedge clk); #1;
    sbq.push_back('0);
    for (int c = 0; c < 4; c++) begin
      reset = (c < 2);
      req_valid = (c < 3) ? 3'b111 : 3'b000;
      er = (c == 2) ? 3'b001 : 3'b000;
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL reset_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== er) begin n_fail++; $display("FAIL reset_ready c=%0d got %b exp %b", c, req_ready, er); end
      predict(er);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    logic [71:0] e;
    logic [2:0] vs [4] = '{3'b001, 3'b010, 3'b010, 3'b000};
    logic fs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] ers [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
    req_addr = {4'd0, 4'd7, 4'd8};
    req_data = {32'h0, 32'h7777_7777, 32'h8888_8888};
    for (int c = 0; c < 4; c++) begin
      req_valid = vs[c];
      flush = fs[c];
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL flush_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== ers[c]) begin n_fail++; $display("FAIL flush_ready c=%0d got %b exp %b", c, req_ready, ers[c]); end
      predict(ers[c]);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    n_asr++; if (rf[8] !== 32'h8888_8888) begin n_fail++; $display("FAIL flush_inflight_r8 got %h exp 88888888", rf[8]); end
    n_asr++; if (rf[7] !== 32'h7777_7777) begin n_fail++; $display("FAIL flush_retry_r7 got %h exp 77777777", rf[7]); end
  endtask

  task automatic test_single;
    logic [71:0] e;
    logic [2:0] vs [2] = '{3'b010, 3'b000};
    req_addr = {4'd0, 4'd2, 4'd0};
    req_data = {32'h0, 32'h5555_5555, 32'h0};
    for (int c = 0; c < 2; c++) begin
      req_valid = vs[c];
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL single_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== vs[c]) begin n_fail++; $display("FAIL single_ready c=%0d got %b exp %b", c, req_ready, vs[c]); end
      predict(vs[c]);
      @(posedge clk); #1;
    end
    n_asr++; if (rf[2] !== 32'h5555_5555) begin n_fail++; $display("FAIL single_r2 got %h exp 55555555", rf[2]); end
  endtask

  task automatic test_collision;
    logic [71:0] e;
    logic [2:0] vs [3] = '{3'b101, 3'b001, 3'b000};
    logic [2:0] ers [3] = '{3'b100, 3'b001, 3'b000};
    req_addr = {4'd1, 4'd0, 4'd1};
    req_data = {32'hBBBB_BBBB, 32'h0, 32'hAAAA_AAAA};
    for (int c = 0; c < 3; c++) begin
      req_valid = vs[c];
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL collide_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== ers[c]) begin n_fail++; $display("FAIL collide_ready c=%0d got %b exp %b", c, req_ready, ers[c]); end
      predict(ers[c]);
      @(posedge clk); #1;
    end
    n_asr++; if (rf[1] !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL collide_r1 got %h exp aaaaaaaa", rf[1]); end
  endtask

  task automatic test_r15;
    logic [71:0] e;
    logic [2:0] vs [3] = '{3'b001, 3'b100, 3'b000};
    req_addr = {4'd6, 4'd0, 4'd15};
    req_data = {32'h6666_6666, 32'h0, 32'hF0F0_F0F0};
    for (int c = 0; c < 3; c++) begin
      req_valid = vs[c];
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL r15_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== vs[c]) begin n_fail++; $display("FAIL r15_ready c=%0d got %b exp %b", c, req_ready, vs[c]); end
      predict(vs[c]);
      @(posedge clk); #1;
    end
    n_asr++; if (rf[15] !== 32'h0) begin n_fail++; $display("FAIL r15_rf_untouched got %h exp 00000000", rf[15]); end
    n_asr++; if (rf[6] !== 32'h6666_6666) begin n_fail++; $display("FAIL r15_next_r6 got %h exp 66666666", rf[6]); end
  endtask

  task automatic test_round_robin;
    logic [71:0] e;
    logic [2:0] er;
    req_addr = {4'd5, 4'd4, 4'd3};
    req_data = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333};
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 6) ? 3'b111 : 3'b000;
      er = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL rr_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== er) begin n_fail++; $display("FAIL rr_ready c=%0d got %b exp %b", c, req_ready, er); end
      predict(er);
      @(posedge clk); #1;
    end
    n_asr++; if (rf[5] !== 32'h5555_5555) begin n_fail++; $display("FAIL rr_r5 got %h exp 55555555", rf[5]); end
  endtask

  task automatic test_reset_midstream;
    logic [71:0] e;
    logic [2:0] vs [4] = '{3'b111, 3'b111, 3'b111, 3'b000};
    logic rs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] ers [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
    req_addr = {4'd11, 4'd10, 4'd9};
    req_data = {32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
    for (int c = 0; c < 4; c++) begin
      req_valid = vs[c];
      reset = rs[c];
      @(negedge clk);
      e = sbq.pop_front();
      n_asr++; if (obs !== e) begin n_fail++; $display("FAIL midreset_out c=%0d got %h exp %h", c, obs, e); end
      n_asr++; if (req_ready !== ers[c]) begin n_fail++; $display("FAIL midreset_ready c=%0d got %b exp %b", c, req_ready, ers[c]); end
      predict(ers[c]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_flush;
    test_single;
    test_collision;
    test_r15;
    test_round_robin;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end
endmodule
